// File: rtl/regread_stage.sv
// Register-read stage: decodes source/destination usage, resolves operands from the
// register file with a same-cycle write-back bypass, tracks in-flight destinations in a
// pending scoreboard, stalls on read-after-write hazards and presents a registered
// valid/ready output stage to execute.
module regread_stage #(
  parameter int unsigned DLEN = 32,
  parameter int unsigned ALEN = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  // Upstream instruction offer
  input  logic            i_id_valid,
  input  logic [31:0]     i_id_instr,
  input  logic [31:0]     i_id_pc,
  output logic            o_id_ready,
  // Register-file read port
  output logic [ALEN-1:0] o_raddr_a,
  output logic [ALEN-1:0] o_raddr_b,
  input  logic [DLEN-1:0] i_rdata_a,
  input  logic [DLEN-1:0] i_rdata_b,
  // Write-back port shared with the register file
  input  logic            i_wb_en,
  input  logic [ALEN-1:0] i_wb_addr,
  input  logic [DLEN-1:0] i_wb_data,
  // Downstream handshake and payload
  output logic            o_ex_valid,
  input  logic            i_ex_ready,
  output logic [31:0]     o_ex_pc,
  output logic [31:0]     o_ex_instr,
  output logic [DLEN-1:0] o_ex_rs1,
  output logic [DLEN-1:0] o_ex_rs2,
  output logic [ALEN-1:0] o_ex_rd,
  output logic            o_ex_rd_wen
);

  localparam int unsigned NumRegs = 1 << ALEN;

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpReg    = 7'b0110011;

  logic [6:0]         opcode;
  logic [ALEN-1:0]    rs1_addr;
  logic [ALEN-1:0]    rs2_addr;
  logic [ALEN-1:0]    rd_addr;
  logic               use_rs1;
  logic               use_rs2;
  logic               writes_rd;
  logic               rd_wen;

  logic               wb_hit_a;
  logic               wb_hit_b;
  logic               busy_a;
  logic               busy_b;
  logic               hazard;
  logic               xfer;

  logic [DLEN-1:0]    rs1_val;
  logic [DLEN-1:0]    rs2_val;

  logic [NumRegs-1:0] pending_q;
  logic [NumRegs-1:0] pending_d;

  logic               ex_valid_q;
  logic [31:0]        ex_pc_q;
  logic [31:0]        ex_instr_q;
  logic [DLEN-1:0]    ex_rs1_q;
  logic [DLEN-1:0]    ex_rs2_q;
  logic [ALEN-1:0]    ex_rd_q;
  logic               ex_rd_wen_q;

  assign opcode   = i_id_instr[6:0];
  assign rd_addr  = i_id_instr[7 +: ALEN];
  assign rs1_addr = i_id_instr[15 +: ALEN];
  assign rs2_addr = i_id_instr[20 +: ALEN];

  assign o_raddr_a = rs1_addr;
  assign o_raddr_b = rs2_addr;

  // Classify the opcode by which sources it reads and whether it writes rd.
  always_comb begin
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    writes_rd = 1'b0;
    case (opcode)
      OpLui, OpAuipc, OpJal: begin
        writes_rd = 1'b1;
      end
      OpJalr, OpLoad, OpImm: begin
        use_rs1   = 1'b1;
        writes_rd = 1'b1;
      end
      OpBranch, OpStore: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OpReg: begin
        use_rs1   = 1'b1;
        use_rs2   = 1'b1;
        writes_rd = 1'b1;
      end
      default: ;
    endcase
  end

  // x0 is never a real destination, so it never enters the scoreboard.
  assign rd_wen = writes_rd && (rd_addr != '0);

  assign wb_hit_a = i_wb_en && (i_wb_addr == rs1_addr);
  assign wb_hit_b = i_wb_en && (i_wb_addr == rs2_addr);

  // Resolve operands: x0 reads zero, a same-cycle write-back overrides the stale file value.
  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (use_rs1 && (rs1_addr != '0)) begin
      rs1_val = wb_hit_a ? i_wb_data : i_rdata_a;
    end
    if (use_rs2 && (rs2_addr != '0)) begin
      rs2_val = wb_hit_b ? i_wb_data : i_rdata_b;
    end
  end

  // A pending source is fine if it is being written back this very cycle (bypass covers it).
  assign busy_a = use_rs1 && (rs1_addr != '0) && pending_q[rs1_addr] && !wb_hit_a;
  assign busy_b = use_rs2 && (rs2_addr != '0) && pending_q[rs2_addr] && !wb_hit_b;
  assign hazard = i_id_valid && (busy_a || busy_b);

  assign o_id_ready = (!ex_valid_q || i_ex_ready) && !hazard;
  assign xfer       = i_id_valid && o_id_ready;

  // Scoreboard next state: clear on write-back, then set on accept so a collision keeps it set.
  always_comb begin
    pending_d = pending_q;
    if (i_wb_en) begin
      pending_d[i_wb_addr] = 1'b0;
    end
    if (xfer && rd_wen) begin
      pending_d[rd_addr] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // Output stage: load on transfer, drain on downstream accept, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q  <= 1'b0;
      ex_pc_q     <= '0;
      ex_instr_q  <= '0;
      ex_rs1_q    <= '0;
      ex_rs2_q    <= '0;
      ex_rd_q     <= '0;
      ex_rd_wen_q <= 1'b0;
    end else if (xfer) begin
      ex_valid_q  <= 1'b1;
      ex_pc_q     <= i_id_pc;
      ex_instr_q  <= i_id_instr;
      ex_rs1_q    <= rs1_val;
      ex_rs2_q    <= rs2_val;
      ex_rd_q     <= rd_addr;
      ex_rd_wen_q <= rd_wen;
    end else if (i_ex_ready) begin
      ex_valid_q  <= 1'b0;
    end
  end

  assign o_ex_valid  = ex_valid_q;
  assign o_ex_pc     = ex_pc_q;
  assign o_ex_instr  = ex_instr_q;
  assign o_ex_rs1    = ex_rs1_q;
  assign o_ex_rs2    = ex_rs2_q;
  assign o_ex_rd     = ex_rd_q;
  assign o_ex_rd_wen = ex_rd_wen_q;

endmodule

// File: tb/tb_regread_stage.sv
// Bench for regread_stage: directed scenarios plus randomized traffic, all checked
// against a transaction-level model of the stage (scoreboard set, register file, output slot).
module tb_regread_stage;

  localparam int DLEN = 32;
  localparam int ALEN = 5;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            id_valid;
  logic [31:0]     id_instr;
  logic [31:0]     id_pc;
  logic            id_ready;
  logic [ALEN-1:0] raddr_a;
  logic [ALEN-1:0] raddr_b;
  logic [DLEN-1:0] rdata_a;
  logic [DLEN-1:0] rdata_b;
  logic            wb_en;
  logic [ALEN-1:0] wb_addr;
  logic [DLEN-1:0] wb_data;
  logic            ex_valid;
  logic            ex_ready;
  logic [31:0]     ex_pc;
  logic [31:0]     ex_instr;
  logic [DLEN-1:0] ex_rs1;
  logic [DLEN-1:0] ex_rs2;
  logic [ALEN-1:0] ex_rd;
  logic            ex_rd_wen;

  always #5 clk = ~clk;

  // Environment register file, read combinationally from the DUT's addresses.
  logic [DLEN-1:0] rf [32];
  assign rdata_a = rf[raddr_a];
  assign rdata_b = rf[raddr_b];

  regread_stage #(.DLEN(DLEN), .ALEN(ALEN)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_id_valid (id_valid),
    .i_id_instr (id_instr),
    .i_id_pc    (id_pc),
    .o_id_ready (id_ready),
    .o_raddr_a  (raddr_a),
    .o_raddr_b  (raddr_b),
    .i_rdata_a  (rdata_a),
    .i_rdata_b  (rdata_b),
    .i_wb_en    (wb_en),
    .i_wb_addr  (wb_addr),
    .i_wb_data  (wb_data),
    .o_ex_valid (ex_valid),
    .i_ex_ready (ex_ready),
    .o_ex_pc    (ex_pc),
    .o_ex_instr (ex_instr),
    .o_ex_rs1   (ex_rs1),
    .o_ex_rs2   (ex_rs2),
    .o_ex_rd    (ex_rd),
    .o_ex_rd_wen(ex_rd_wen)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Model state: set of in-flight destinations and the single output slot.
  bit          m_pend [32];
  bit          m_valid;
  logic [31:0] m_pc, m_instr, m_rs1, m_rs2;
  logic [4:0]  m_rd;
  bit          m_rdw;
  bit          last_rdy;

  localparam logic [6:0] OP_LIST [10] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                                          7'b0000011, 7'b0010011, 7'b1100011, 7'b0100011,
                                          7'b0110011, 7'b1111111};

  // Instruction classes by number of sources read and whether rd is written.
  function automatic void classify(input logic [6:0] op, output int nsrc, output bit wr);
    nsrc = 0;
    wr   = 0;
    if (op == 7'b0110111 || op == 7'b0010111 || op == 7'b1101111) wr = 1;
    else if (op == 7'b1100111 || op == 7'b0000011 || op == 7'b0010011) begin
      nsrc = 1;
      wr = 1;
    end
    else if (op == 7'b1100011 || op == 7'b0100011) nsrc = 2;
    else if (op == 7'b0110011) begin
      nsrc = 2;
      wr = 1;
    end
  endfunction

  function automatic logic [31:0] r_add(input logic [4:0] rd, rs1, rs2);
    return {7'd0, rs2, rs1, 3'd0, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] i_form(input logic [6:0] op, input logic [4:0] rd, rs1,
                                         input logic [11:0] imm, input logic [2:0] f3);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic bit stalled_on(input logic [4:0] a, input bit we, input logic [4:0] wa);
    return (a != 0) && m_pend[a] && !(we && wa == a);
  endfunction

  function automatic logic [31:0] opnd(input logic [4:0] a, input bit we, input logic [4:0] wa,
                                       input logic [31:0] wd);
    if (a == 0) return 32'd0;
    if (we && wa == a) return wd;
    return rf[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_pend[i] = 0;
    m_valid = 0;
  endtask

  // One clock: drive, check ready against the model, clock, update model, check outputs.
  task automatic cycle(input bit v, input logic [31:0] instr, input logic [31:0] pc,
                       input bit exr, input bit we, input logic [4:0] wa,
                       input logic [31:0] wd);
    int    nsrc;
    bit    wr, haz, exp_rdy, xfer;
    logic [4:0] a1, a2, rd;
    logic [31:0] v1, v2;
    @(negedge clk);
    id_valid = v;
    id_instr = instr;
    id_pc    = pc;
    ex_ready = exr;
    wb_en    = we;
    wb_addr  = wa;
    wb_data  = wd;
    #1;
    classify(instr[6:0], nsrc, wr);
    a1 = instr[19:15];
    a2 = instr[24:20];
    rd = instr[11:7];
    haz = v && ((nsrc >= 1 && stalled_on(a1, we, wa)) || (nsrc == 2 && stalled_on(a2, we, wa)));
    exp_rdy = (!m_valid || exr) && !haz;
    check_eq("id_ready", 64'(id_ready), 64'(exp_rdy));
    last_rdy = exp_rdy;
    xfer = v && exp_rdy;
    v1 = (nsrc >= 1) ? opnd(a1, we, wa, wd) : 32'd0;
    v2 = (nsrc == 2) ? opnd(a2, we, wa, wd) : 32'd0;
    @(posedge clk);
    #1;
    if (we) m_pend[wa] = 0;
    if (xfer) begin
      m_valid = 1;
      m_pc    = pc;
      m_instr = instr;
      m_rs1   = v1;
      m_rs2   = v2;
      m_rd    = rd;
      m_rdw   = wr && (rd != 0);
      if (m_rdw) m_pend[rd] = 1;
    end else if (exr) begin
      m_valid = 0;
    end
    if (we) rf[wa] = wd;
    check_eq("ex_valid", 64'(ex_valid), 64'(m_valid));
    if (m_valid) begin
      check_eq("ex_pc", 64'(ex_pc), 64'(m_pc));
      check_eq("ex_instr", 64'(ex_instr), 64'(m_instr));
      check_eq("ex_rs1", 64'(ex_rs1), 64'(m_rs1));
      check_eq("ex_rs2", 64'(ex_rs2), 64'(m_rs2));
      check_eq("ex_rd", 64'(ex_rd), 64'(m_rd));
      check_eq("ex_rd_wen", 64'(ex_rd_wen), 64'(m_rdw));
    end
  endtask

  task automatic idle(input bit exr);
    cycle(0, 32'h0000_0013, 32'd0, exr, 0, 5'd0, 32'd0);
  endtask

  initial begin
    logic [31:0] ins;
    id_valid = 0;
    id_instr = 0;
    id_pc    = 0;
    ex_ready = 0;
    wb_en    = 0;
    wb_addr  = 0;
    wb_data  = 0;
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    rf[0] = 0;
    model_reset();

    // Reset state
    #12;
    check_eq("rst_ex_valid", 64'(ex_valid), 64'd0);
    check_eq("rst_ex_pc", 64'(ex_pc), 64'd0);
    check_eq("rst_ex_instr", 64'(ex_instr), 64'd0);
    check_eq("rst_ex_rs1", 64'(ex_rs1), 64'd0);
    check_eq("rst_ex_rs2", 64'(ex_rs2), 64'd0);
    check_eq("rst_ex_rd", 64'(ex_rd), 64'd0);
    check_eq("rst_ex_rd_wen", 64'(ex_rd_wen), 64'd0);
    @(negedge clk);
    rst_n = 1;

    // Independent back-to-back stream
    rf[3] = 7;
    rf[4] = 9;
    cycle(1, i_form(7'b0010011, 5'd1, 5'd0, 12'd5, 3'd0), 32'h100, 1, 0, 5'd0, 32'd0);
    check_eq("s1_ready0", 64'(id_ready), 64'd1);
    cycle(1, r_add(5'd2, 5'd3, 5'd4), 32'h104, 1, 0, 5'd0, 32'd0);
    check_eq("s1_ready1", 64'(last_rdy), 64'd1);
    check_eq("s1_valid", 64'(ex_valid), 64'd1);
    check_eq("s1_rs1", 64'(ex_rs1), 64'd7);
    check_eq("s1_rs2", 64'(ex_rs2), 64'd9);
    cycle(0, 32'd0, 32'd0, 1, 1, 5'd1, 32'd5);
    cycle(0, 32'd0, 32'd0, 1, 1, 5'd2, 32'd16);

    // RAW stall on load destination
    cycle(1, i_form(7'b0000011, 5'd5, 5'd0, 12'd0, 3'd2), 32'h200, 1, 0, 5'd0, 32'd0);
    for (int k = 0; k < 2; k++) begin
      cycle(1, r_add(5'd6, 5'd5, 5'd5), 32'h204, 1, 0, 5'd0, 32'd0);
      check_eq("raw_stall", 64'(last_rdy), 64'd0);
    end
    cycle(1, r_add(5'd6, 5'd5, 5'd5), 32'h204, 1, 1, 5'd5, 32'h1234);
    check_eq("raw_go", 64'(last_rdy), 64'd1);
    check_eq("raw_rs1", 64'(ex_rs1), 64'h1234);
    check_eq("raw_rs2", 64'(ex_rs2), 64'h1234);

    // x0 handling
    cycle(1, i_form(7'b0010011, 5'd0, 5'd0, 12'd1, 3'd0), 32'h280, 1, 0, 5'd0, 32'd0);
    check_eq("x0_rd_wen", 64'(ex_rd_wen), 64'd0);
    cycle(1, r_add(5'd7, 5'd0, 5'd0), 32'h284, 1, 1, 5'd0, 32'hFFFF);
    check_eq("x0_ready", 64'(last_rdy), 64'd1);
    check_eq("x0_rs1", 64'(ex_rs1), 64'd0);
    check_eq("x0_rs2", 64'(ex_rs2), 64'd0);
    ins = r_add(5'd12, 5'd0, 5'd0);
    cycle(1, ins, 32'h288, 1, 0, 5'd0, 32'd0);
    check_eq("x0_no_pend", 64'(last_rdy), 64'd1);

    // Backpressure
    ins = i_form(7'b0010011, 5'd10, 5'd0, 12'd3, 3'd0);
    cycle(1, ins, 32'h300, 1, 0, 5'd0, 32'd0);
    for (int k = 0; k < 3; k++) begin
      cycle(1, i_form(7'b0010011, 5'd11, 5'd0, 12'd4, 3'd0), 32'h304, 0, 0, 5'd0, 32'd0);
      check_eq("bp_ready", 64'(last_rdy), 64'd0);
      check_eq("bp_hold_pc", 64'(ex_pc), 64'h300);
      check_eq("bp_hold_instr", 64'(ex_instr), 64'(ins));
    end
    cycle(1, i_form(7'b0010011, 5'd11, 5'd0, 12'd4, 3'd0), 32'h304, 1, 0, 5'd0, 32'd0);
    check_eq("bp_release", 64'(last_rdy), 64'd1);
    check_eq("bp_new_pc", 64'(ex_pc), 64'h304);

    // Set/clear collision on x5
    cycle(1, i_form(7'b0010011, 5'd5, 5'd0, 12'd9, 3'd0), 32'h400, 1, 1, 5'd5, 32'h77);
    check_eq("col_accept", 64'(last_rdy), 64'd1);
    for (int k = 0; k < 2; k++) begin
      cycle(1, r_add(5'd8, 5'd5, 5'd0), 32'h404, 1, 0, 5'd0, 32'd0);
      check_eq("col_stall", 64'(last_rdy), 64'd0);
    end
    cycle(1, r_add(5'd8, 5'd5, 5'd0), 32'h404, 1, 1, 5'd5, 32'h55);
    check_eq("col_go", 64'(last_rdy), 64'd1);
    check_eq("col_rs1", 64'(ex_rs1), 64'h55);

    // Reset mid-operation
    cycle(1, i_form(7'b0010011, 5'd3, 5'd0, 12'd3, 3'd0), 32'h500, 1, 0, 5'd0, 32'd0);
    check_eq("mr_valid_pre", 64'(ex_valid), 64'd1);
    @(negedge clk);
    id_valid = 0;
    ex_ready = 0;
    wb_en    = 0;
    #2;
    rst_n = 0;
    #1;
    check_eq("mr_valid", 64'(ex_valid), 64'd0);
    check_eq("mr_pc", 64'(ex_pc), 64'd0);
    check_eq("mr_rd", 64'(ex_rd), 64'd0);
    check_eq("mr_rd_wen", 64'(ex_rd_wen), 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    cycle(1, r_add(5'd9, 5'd3, 5'd0), 32'h600, 1, 0, 5'd0, 32'd0);
    check_eq("mr_no_stall", 64'(last_rdy), 64'd1);

    // Randomized traffic
    for (int n = 0; n < 500; n++) begin
      logic [31:0] r;
      bit v, exr, we;
      r = $urandom;
      r[6:0]   = OP_LIST[$urandom_range(0, 9)];
      r[11:7]  = 5'($urandom_range(0, 7));
      r[19:15] = 5'($urandom_range(0, 7));
      r[24:20] = 5'($urandom_range(0, 7));
      v   = ($urandom_range(0, 9) < 8);
      exr = ($urandom_range(0, 9) < 7);
      we  = ($urandom_range(0, 9) < 3);
      cycle(v, r, $urandom, exr, we, 5'($urandom_range(0, 7)), $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
